// File: rtl/dispatch_pkg.sv
// Shared FSM encoding and descriptor field positions for the kernel dispatcher.
package dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int JOB_ID_LSB     = 8;
  localparam int JOB_ID_MSB     = 31;
  localparam int KERNEL_NUM_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first set request at or after i_ptr; purely combinational,
// zero latency, no backpressure (o_any low when nothing is requesting).
module rr_arbiter
  import dispatch_pkg::*;
#(
  parameter int N  = KERNEL_NUM_DEF,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_grant_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;

  always_comb begin
    // bit k of w_rot is the request k slots after the pointer
    w_rot       = N'({i_req, i_req} >> i_ptr);
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any       = 1'b1;
        o_grant_idx = PW'((int'(i_ptr) + k) % N);
      end
    end
    if (o_any) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/kernel_dispatcher.sv
// Buffers host descriptors and issues each to a free kernel in round-robin order;
// 2 cycles from accept to kernel_start, 1 job per 2 cycles; desc_ready drops when the FIFO is full.
module kernel_dispatcher
  import dispatch_pkg::*;
#(
  parameter int KERNEL_NUM = KERNEL_NUM_DEF,
  parameter int DESC_WIDTH = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_desc_valid,
  output logic                  o_desc_ready,
  input  logic [DESC_WIDTH-1:0] i_desc_data,
  input  logic                  i_stop_req,
  output logic [KERNEL_NUM-1:0] o_kernel_start,
  input  logic [KERNEL_NUM-1:0] i_kernel_complete,
  output logic [DESC_WIDTH-1:0] o_system_register,
  output logic [KERNEL_NUM-1:0] o_kernel_busy,
  output logic                  o_real_done,
  output logic                  o_err_spurious,
  output logic [31:0]           o_jobs_issued,
  output logic [31:0]           o_jobs_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DESC_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [AW:0]           w_count;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_latch;
  logic [KERNEL_NUM-1:0] w_grant;
  logic [PW-1:0]         w_grant_idx;
  logic                  w_any;
  logic [KERNEL_NUM-1:0] r_grant_oh;
  logic [PW-1:0]         r_grant_idx;
  logic [PW-1:0]         r_rr_ptr;
  logic [DESC_WIDTH-1:0] r_sysreg;
  logic [KERNEL_NUM-1:0] r_busy;
  logic [KERNEL_NUM-1:0] w_busy_set;
  logic [KERNEL_NUM-1:0] w_cmp_hit;
  logic                  r_err;
  logic [31:0]           r_jobs_issued;
  logic [31:0]           r_jobs_done;

  assign w_count      = r_wptr - r_rptr;
  assign w_fifo_empty = (w_count == '0);
  assign o_desc_ready = (w_count != FULL_CNT);
  assign w_push       = i_desc_valid & o_desc_ready;
  assign w_pop        = (r_state == ISSUE);
  assign w_busy_set   = w_pop ? r_grant_oh : '0;
  assign w_cmp_hit    = i_kernel_complete & r_busy;

  rr_arbiter #(.N(KERNEL_NUM), .PW(PW)) u_arb (
    .i_req       (~r_busy),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Storage carries no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_desc_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && w_any) begin
          w_state_nxt = ISSUE;
          w_latch     = 1'b1;
        end else if (i_stop_req && w_fifo_empty) begin
          w_state_nxt = DRAIN;
        end
      end
      ISSUE: w_state_nxt = IDLE;
      DRAIN: begin
        if (!w_fifo_empty) begin
          w_state_nxt = IDLE;
        end else if (r_busy == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!i_stop_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_grant_oh    <= '0;
      r_grant_idx   <= '0;
      r_rr_ptr      <= '0;
      r_sysreg      <= '0;
      r_busy        <= '0;
      r_err         <= 1'b0;
      r_jobs_issued <= '0;
      r_jobs_done   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_latch) begin
        r_grant_oh  <= w_grant;
        r_grant_idx <= w_grant_idx;
        r_sysreg    <= r_mem[r_rptr[AW-1:0]];
      end
      if (w_pop) begin
        r_rptr        <= r_rptr + 1'b1;
        r_jobs_issued <= r_jobs_issued + 32'd1;
        r_rr_ptr      <= (r_grant_idx == PW'(KERNEL_NUM - 1)) ? '0 : r_grant_idx + 1'b1;
      end
      // Completion and issue touch different kernels, so both land in one update.
      r_busy      <= (r_busy & ~i_kernel_complete) | w_busy_set;
      r_err       <= r_err | (|(i_kernel_complete & ~r_busy));
      r_jobs_done <= r_jobs_done + 32'($countones(w_cmp_hit));
    end
  end

  assign o_kernel_start    = (r_state == ISSUE) ? r_grant_oh : '0;
  assign o_system_register = r_sysreg;
  assign o_kernel_busy     = r_busy;
  assign o_real_done       = (r_state == DONE);
  assign o_err_spurious    = r_err;
  assign o_jobs_issued     = r_jobs_issued;
  assign o_jobs_done       = r_jobs_done;

endmodule

// File: tb/tb_kernel_dispatcher.sv
// Directed, table-driven and randomized checks of kernel_dispatcher against a transaction-level model.
module tb_kernel_dispatcher;
  import dispatch_pkg::*;

  localparam int KN = 8;
  localparam int DW = 512;
  localparam int FD = 16;
  localparam int KW = $clog2(KN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_desc_valid = 1'b0;
  logic [DW-1:0] i_desc_data = '0;
  logic          i_stop_req = 1'b0;
  logic [KN-1:0] i_kernel_complete = '0;
  logic          o_desc_ready;
  logic [KN-1:0] o_kernel_start;
  logic [DW-1:0] o_system_register;
  logic [KN-1:0] o_kernel_busy;
  logic          o_real_done;
  logic          o_err_spurious;
  logic [31:0]   o_jobs_issued;
  logic [31:0]   o_jobs_done;

  always #5 clk = ~clk;

  kernel_dispatcher #(.KERNEL_NUM(KN), .DESC_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_desc_valid      (i_desc_valid),
    .o_desc_ready      (o_desc_ready),
    .i_desc_data       (i_desc_data),
    .i_stop_req        (i_stop_req),
    .o_kernel_start    (o_kernel_start),
    .i_kernel_complete (i_kernel_complete),
    .o_system_register (o_system_register),
    .o_kernel_busy     (o_kernel_busy),
    .o_real_done       (o_real_done),
    .o_err_spurious    (o_err_spurious),
    .o_jobs_issued     (o_jobs_issued),
    .o_jobs_done       (o_jobs_done)
  );

  int checks = 0;
  int errors = 0;

  logic          rec_on = 1'b0;
  logic [KN-1:0] st_q[$];
  logic [23:0]   id_q[$];

  typedef struct {
    logic [KN-1:0] cmp;
    logic [KN-1:0] busy;
    logic [31:0]   done;
    logic          err;
  } vec_t;
  vec_t tbl[6];

  logic [DW-1:0] mq[$];
  logic [KN-1:0] busy_m = '0;
  int            ptr_m = 0;
  logic [31:0]   iss_m = '0;
  logic [31:0]   done_m = '0;
  logic          rnd_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rec_on && o_kernel_start != '0) begin
      st_q.push_back(o_kernel_start);
      id_q.push_back(o_system_register[JOB_ID_MSB:JOB_ID_LSB]);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [23:0] id);
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    d[JOB_ID_MSB:JOB_ID_LSB] = id;
    return d;
  endfunction

  // First idle kernel at or after ptr, wrapping; -1 when every kernel is busy.
  function automatic int rr_pick(input logic [KN-1:0] busy, input int ptr);
    for (int k = 0; k < KN; k++) begin
      int idx;
      idx = (ptr + k) % KN;
      if (!busy[KW'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    i_desc_valid = 1'b0;
    i_stop_req = 1'b0;
    i_kernel_complete = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 64'(o_desc_ready), 64'd1);
    chk({tag, "_start"}, 64'(o_kernel_start), 64'd0);
    chk_w({tag, "_sysreg"}, o_system_register, '0);
    chk({tag, "_busy"}, 64'(o_kernel_busy), 64'd0);
    chk({tag, "_real_done"}, 64'(o_real_done), 64'd0);
    chk({tag, "_err"}, 64'(o_err_spurious), 64'd0);
    chk({tag, "_issued"}, 64'(o_jobs_issued), 64'd0);
    chk({tag, "_done"}, 64'(o_jobs_done), 64'd0);
  endtask

  task automatic push_n(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) begin
      i_desc_valid = 1'b1;
      i_desc_data = mk(base + 24'(i));
      step();
    end
    i_desc_valid = 1'b0;
  endtask

  task automatic wait_busy(input string nm, input logic [KN-1:0] v, input int budget);
    int n;
    n = 0;
    while (o_kernel_busy != v && n < budget) begin
      step();
      n++;
    end
    chk(nm, 64'(o_kernel_busy), 64'(v));
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (o_kernel_start == '0 && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d1;
    tbl[0] = '{cmp: 8'h01, busy: 8'hFE, done: 32'd1, err: 1'b0};
    tbl[1] = '{cmp: 8'h06, busy: 8'hF8, done: 32'd3, err: 1'b0};
    tbl[2] = '{cmp: 8'hF0, busy: 8'h08, done: 32'd7, err: 1'b0};
    tbl[3] = '{cmp: 8'h18, busy: 8'h00, done: 32'd8, err: 1'b1};
    tbl[4] = '{cmp: 8'h00, busy: 8'h00, done: 32'd8, err: 1'b1};
    tbl[5] = '{cmp: 8'h80, busy: 8'h00, done: 32'd8, err: 1'b1};

    // Single job: accepted in cycle 0, start in cycle 2.
    do_reset();
    check_reset("reset");
    d1 = mk(24'h00ABCD);
    i_desc_valid = 1'b1;
    i_desc_data = d1;
    step();
    i_desc_valid = 1'b0;
    chk("t1_start_c1", 64'(o_kernel_start), 64'd0);
    step();
    chk("t1_start_c2", 64'(o_kernel_start), 64'h01);
    chk("t1_id", 64'(o_system_register[JOB_ID_MSB:JOB_ID_LSB]), 64'h00ABCD);
    chk_w("t1_sysreg", o_system_register, d1);
    step();
    chk("t1_busy", 64'(o_kernel_busy), 64'h01);
    chk("t1_issued", 64'(o_jobs_issued), 64'd1);
    chk("t1_start_c3", 64'(o_kernel_start), 64'd0);
    chk_w("t1_sysreg_held", o_system_register, d1);

    // Fill all kernels, then FIFO-full backpressure and refill after completions.
    do_reset();
    rec_on = 1'b1;
    push_n(10, 24'h000100);
    wait_busy("t2_all_busy", 8'hFF, 40);
    repeat (4) step();
    rec_on = 1'b0;
    chk("t2_nstarts", 64'(st_q.size()), 64'd8);
    for (int i = 0; i < st_q.size() && i < KN; i++) begin
      chk($sformatf("t2_start%0d", i), 64'(st_q[i]), 64'd1 << i);
      chk($sformatf("t2_id%0d", i), 64'(id_q[i]), 64'h100 + 64'(i));
    end
    push_n(14, 24'h000200);
    chk("t2_full_ready", 64'(o_desc_ready), 64'd0);
    i_desc_valid = 1'b1;
    i_desc_data = mk(24'h00DEAD);
    step();
    step();
    i_desc_valid = 1'b0;
    chk("t2_full_hold", 64'(o_desc_ready), 64'd0);
    i_kernel_complete = 8'h08;
    step();
    i_kernel_complete = '0;
    chk("t2_c1_start", 64'(o_kernel_start), 64'd0);
    step();
    chk("t2_c2_start", 64'(o_kernel_start), 64'h08);
    chk("t2_c2_id", 64'(o_system_register[JOB_ID_MSB:JOB_ID_LSB]), 64'h108);
    step();
    chk("t2_c3_busy", 64'(o_kernel_busy), 64'hFF);
    chk("t2_c3_ready", 64'(o_desc_ready), 64'd1);
    i_kernel_complete = 8'hFF;
    step();
    i_kernel_complete = '0;
    chk("t2_all_cmp_busy", 64'(o_kernel_busy), 64'd0);
    chk("t2_all_cmp_done", 64'(o_jobs_done), 64'd9);
    chk("t2_all_cmp_err", 64'(o_err_spurious), 64'd0);
    step();
    chk("t2_next_start", 64'(o_kernel_start), 64'h10);
    chk("t2_next_id", 64'(o_system_register[JOB_ID_MSB:JOB_ID_LSB]), 64'h109);

    // Round-robin: pointer left at 3 with every kernel idle.
    do_reset();
    push_n(3, 24'h000300);
    wait_busy("t3_busy3", 8'h07, 30);
    i_kernel_complete = 8'h07;
    step();
    i_kernel_complete = '0;
    chk("t3_idle", 64'(o_kernel_busy), 64'd0);
    push_n(1, 24'h000333);
    wait_start(10);
    chk("t3_rr_start", 64'(o_kernel_start), 64'h08);
    chk("t3_rr_id", 64'(o_system_register[JOB_ID_MSB:JOB_ID_LSB]), 64'h333);

    // Completion table from an all-busy state.
    do_reset();
    push_n(8, 24'h000400);
    wait_busy("t4_all_busy", 8'hFF, 40);
    for (int r = 0; r < 6; r++) begin
      i_kernel_complete = tbl[r].cmp;
      step();
      i_kernel_complete = '0;
      chk($sformatf("t4_row%0d_busy", r), 64'(o_kernel_busy), 64'(tbl[r].busy));
      chk($sformatf("t4_row%0d_done", r), 64'(o_jobs_done), 64'(tbl[r].done));
      chk($sformatf("t4_row%0d_err", r), 64'(o_err_spurious), 64'(tbl[r].err));
    end

    // Drain with three kernels busy.
    do_reset();
    push_n(3, 24'h000500);
    wait_busy("t5_busy3", 8'h07, 30);
    i_stop_req = 1'b1;
    step();
    step();
    chk("t5_rd_early", 64'(o_real_done), 64'd0);
    i_kernel_complete = 8'h01;
    step();
    i_kernel_complete = 8'h02;
    step();
    i_kernel_complete = '0;
    step();
    chk("t5_rd_two_left", 64'(o_real_done), 64'd0);
    i_kernel_complete = 8'h04;
    step();
    i_kernel_complete = '0;
    chk("t5_rd_t1", 64'(o_real_done), 64'd0);
    chk("t5_busy_t1", 64'(o_kernel_busy), 64'd0);
    step();
    chk("t5_rd_t2", 64'(o_real_done), 64'd1);
    step();
    chk("t5_rd_hold", 64'(o_real_done), 64'd1);
    i_stop_req = 1'b0;
    step();
    chk("t5_rd_fall", 64'(o_real_done), 64'd0);

    // Reset asserted during ISSUE with five descriptors queued.
    do_reset();
    push_n(8, 24'h000600);
    wait_busy("t6_all_busy", 8'hFF, 40);
    push_n(5, 24'h000700);
    i_kernel_complete = 8'h01;
    step();
    i_kernel_complete = '0;
    step();
    chk("t6_issue_start", 64'(o_kernel_start), 64'h01);
    rst_n = 1'b0;
    #1;
    check_reset("t6_in_reset");
    step();
    step();
    rst_n = 1'b1;
    chk("t6_ready_after", 64'(o_desc_ready), 64'd1);
    i_kernel_complete = 8'h02;
    step();
    i_kernel_complete = '0;
    chk("t6_late_err", 64'(o_err_spurious), 64'd1);
    chk("t6_late_done", 64'(o_jobs_done), 64'd0);

    // Randomized traffic against the queue/bitmap model.
    do_reset();
    mq.delete();
    busy_m = '0;
    ptr_m = 0;
    iss_m = '0;
    done_m = '0;
    rnd_on = 1'b1;
    fork
      begin : drv
        int n;
        for (int c = 0; c < 3000; c++) begin
          i_desc_valid = ($urandom_range(0, 99) < 45);
          i_desc_data = mk(24'($urandom()));
          i_kernel_complete = busy_m & KN'($urandom()) & KN'($urandom());
          step();
        end
        i_desc_valid = 1'b0;
        n = 0;
        while ((mq.size() != 0 || busy_m != '0) && n < 2000) begin
          i_kernel_complete = busy_m & KN'($urandom());
          step();
          n++;
        end
        i_kernel_complete = '0;
        step();
        step();
        rnd_on = 1'b0;
      end
      begin : mon
        int pend_prev;
        int g_now;
        logic rdy_m;
        logic [KN-1:0] hits;
        pend_prev = -1;
        while (rnd_on) begin
          @(negedge clk);
          g_now = rr_pick(busy_m, ptr_m);
          rdy_m = (mq.size() < FD);
          chk("rnd_ready", 64'(o_desc_ready), 64'(rdy_m));
          chk("rnd_busy", 64'(o_kernel_busy), 64'(busy_m));
          chk("rnd_issued", 64'(o_jobs_issued), 64'(iss_m));
          chk("rnd_done", 64'(o_jobs_done), 64'(done_m));
          chk("rnd_err", 64'(o_err_spurious), 64'd0);
          hits = i_kernel_complete & busy_m;
          done_m += 32'($countones(hits));
          busy_m &= ~i_kernel_complete;
          if (o_kernel_start != '0) begin
            if (pend_prev < 0 || mq.size() == 0) begin
              chk("rnd_unexpected_start", 64'(o_kernel_start), 64'd0);
            end else begin
              chk("rnd_grant", 64'(o_kernel_start), 64'd1 << pend_prev);
              chk_w("rnd_sysreg", o_system_register, mq[0]);
              void'(mq.pop_front());
              busy_m[KW'(pend_prev)] = 1'b1;
              ptr_m = (pend_prev + 1) % KN;
              iss_m++;
            end
          end
          if (i_desc_valid && rdy_m) mq.push_back(i_desc_data);
          pend_prev = g_now;
        end
      end
    join
    chk("rnd_queue_drained", 64'(mq.size()), 64'd0);
    chk("rnd_final_busy", 64'(o_kernel_busy), 64'd0);
    chk("rnd_final_issued", 64'(o_jobs_issued), 64'(iss_m));
    chk("rnd_final_done", 64'(o_jobs_done), 64'(iss_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_dispatcher.md
# kernel_dispatcher

Front-end scheduler for the multi-kernel engine. It buffers host job descriptors and dispatches each to a free kernel using round-robin order. For each dispatch it pulses that kernel's `kernel_start` and presents the descriptor on `system_register`, which is the interface the completion manager uses to capture thread IDs. It tracks per-kernel busy state from `kernel_complete` and raises `real_done` once a host stop request has been fully drained.

## Interface
- `KERNEL_NUM`, 8: number of kernels; `kernel_start`/`kernel_complete` width.
- `DESC_WIDTH`, 512: descriptor width; bits [31:8] are the job/thread ID.
- `FIFO_DEPTH`, 16: descriptor FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `desc_valid`  in  1  host descriptor valid.
- `desc_ready`  out  1  FIFO not full; 1 after reset.
- `desc_data`  in  DESC_WIDTH  descriptor payload.
- `stop_req`  in  1  level; host will push no more jobs.
- `kernel_start`  out  KERNEL_NUM  one-hot, one-cycle start pulse; reset 0.
- `kernel_complete`  in  KERNEL_NUM  one-cycle done pulses; multiple bits may be set.
- `system_register`  out  DESC_WIDTH  dispatched descriptor; held until next dispatch; reset 0.
- `kernel_busy`  out  KERNEL_NUM  per-kernel busy flags; reset 0.
- `real_done`  out  1  level; all work drained after stop; reset 0.
- `err_spurious`  out  1  sticky; `kernel_complete` seen on an idle kernel; reset 0.
- `jobs_issued`, `jobs_done`  out  32 each  wrapping counters; reset 0.

## Operation
- **FIFO.** Push when `desc_valid & desc_ready`. Pop only in ISSUE. Push and pop in the same cycle leaves the count unchanged. A push while full is impossible because `desc_ready` = 0.
- **State IDLE.**
  - FIFO non-empty and `~kernel_busy != 0` → ISSUE, latching grant `g` from the arbiter.
  - Otherwise, `stop_req` and FIFO empty → DRAIN.
  - Otherwise stay in IDLE.
- **State ISSUE** (exactly 1 cycle):
  - `kernel_start[g]` = 1.
  - `system_register` ← FIFO head, registered, visible in this same cycle. It is loaded on the IDLE→ISSUE edge.
  - Pop FIFO; set `kernel_busy[g]`; increment `jobs_issued`.
  - Advance the RR pointer to g+1 mod KERNEL_NUM.
  - Next state is IDLE.
- **State DRAIN.** Move to DONE when `kernel_busy == 0`. If the FIFO becomes non-empty (host broke the protocol), go back to IDLE.
- **State DONE.** `real_done` = 1 and is held. When `stop_req` = 0, go to IDLE; `real_done` drops on that transition.
- **Completion.** For each bit i with `kernel_complete[i]`:
  - If `kernel_busy[i]`: clear it and increment `jobs_done` once per bit (add popcount).
  - If not busy: set `err_spurious`.
- **Arbitration.** Search starts at the RR pointer over the eligible vector `~kernel_busy`, using the registered busy value. A kernel completing in cycle t becomes eligible in cycle t+1.
- **Simultaneous events.** A completion on kernel j and an issue to kernel k≠j in the same cycle are both applied.
- **Reset mid-operation.** All state, the FIFO, and the counters clear immediately. In-flight kernels are forgotten. A late `kernel_complete` after reset sets `err_spurious`.

## Timing
- Descriptor accepted in cycle 0 with an empty FIFO and a free kernel: count = 1 in cycle 1 (IDLE decides), so `kernel_start` is high in cycle 2.
- Sustained dispatch rate: 1 job per 2 cycles.
- `system_register` is stable for at least the `kernel_start` cycle and stays held until the next ISSUE.
- Last completion in cycle t while in DRAIN: busy = 0 in t+1, DONE in t+2, so `real_done` rises in t+2.
- `desc_ready` is combinational from the registered FIFO count. There is no combinational path from `desc_valid`.

## Structure
- **Shared package `dispatch_pkg`:**
  - State enum: IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
  - `JOB_ID_LSB`=8, `JOB_ID_MSB`=31.
  - Default `KERNEL_NUM`.
- **Sub-module `rr_arbiter`:** parameter N. Inputs `req[N]` and `ptr[log2 N]`. Outputs `grant` (one-hot, combinational), `grant_idx`, and `any`.
- The FIFO is inline: a register array with read/write pointers one bit wider than the address.

## Test plan
- **Single job.** Reset, push one descriptor with ID 0x00ABCD → `kernel_start` = 0x01 in cycle 2, `system_register[31:8]` = 0x00ABCD, `kernel_busy` = 0x01.
- **Fill all kernels.** Push 10 descriptors with none completing → starts go to kernels 0–7 in order. Two descriptors remain queued. Pulse `kernel_complete` = 0x08 → next start = 0x08 two cycles later.
- **Round-robin fairness.** All kernels idle, pointer = 3, push one job → start = 0x08, not 0x01.
- **Simultaneous completes.** `kernel_complete` = 0xFF with all busy → `kernel_busy` = 0, `jobs_done` increments by 8. Completion on an idle kernel → `err_spurious` = 1.
- **Drain and done.** Assert `stop_req` with 3 kernels busy and FIFO empty → `real_done` stays 0 until the last complete, rises 2 cycles after it, and falls once `stop_req` is deasserted.
- **Reset mid-operation.** Assert `rst_n` low while in ISSUE with FIFO count 5 → all outputs return to their reset values and `desc_ready` = 1 after release.
